// File: rtl/mic1_mem_pkg.sv
// Shared types for the Mic-1 main_memory arbiter.
// Both requesters and the sequencer import from here.
package mic1_mem_pkg;

  localparam int MEM_ADDR_W = 9;
  localparam int MEM_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE
  } ctrl_state_t;

  typedef enum logic {
    GNT_WORD,
    GNT_FETCH
  } grant_t;

  typedef enum logic {
    OP_RD,
    OP_WR
  } op_t;

endpackage

// File: rtl/mem_arbiter_rr.sv
// Two-way round-robin arbiter: bit 0 = word port, bit 1 = fetch.
// After reset the fetch side counts as last served, so word wins the first tie.
module rr_arbiter2
  import mic1_mem_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] grant
);

  grant_t last;

  always_comb begin
    grant = req;
    if (&req) begin
      grant = (last == GNT_FETCH) ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last <= GNT_FETCH;
    end else if (update && |grant) begin
      last <= grant[1] ? GNT_FETCH : GNT_WORD;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Sequences single-port main_memory for the Mic-1 word (MAR/MDR)
// and instruction-fetch (PC/MBR) ports, one transaction in flight.
module mem_arbiter
  import mic1_mem_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              word_rd,
  input  logic              word_wr,
  input  logic [ADDR_W-1:0] word_addr,
  input  logic [DATA_W-1:0] word_wdata,
  output logic              word_ack,
  output logic              word_rvalid,
  output logic [DATA_W-1:0] word_rdata,
  output logic              word_wdone,
  input  logic              fetch_req,
  input  logic [ADDR_W+1:0] fetch_addr,
  output logic              fetch_ack,
  output logic              fetch_rvalid,
  output logic [7:0]        fetch_byte,
  output logic              mem_wen,
  output logic              mem_ren,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [ADDR_W-1:0] mem_raddr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              proto_err
);

  ctrl_state_t state;
  op_t         op;
  grant_t      owner;
  logic [1:0]  lane;
  logic [1:0]  req;
  logic [1:0]  grant;
  logic        take;
  logic [7:0]  lane_byte;

  assign req  = {fetch_req, word_rd | word_wr};
  assign take = (state == IDLE) && !rst && (|req);

  rr_arbiter2 u_rr (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .update (take),
    .grant  (grant)
  );

  // Acks are combinational so a grant lands in the IDLE cycle itself.
  assign word_ack  = take & grant[0];
  assign fetch_ack = take & grant[1];

  // Big-endian lane: byte offset 0 is the most significant byte.
  always_comb begin
    lane_byte = mem_rdata[DATA_W-1 -: 8];
    unique case (lane)
      2'd0: lane_byte = mem_rdata[DATA_W-1  -: 8];
      2'd1: lane_byte = mem_rdata[DATA_W-9  -: 8];
      2'd2: lane_byte = mem_rdata[DATA_W-17 -: 8];
      2'd3: lane_byte = mem_rdata[DATA_W-25 -: 8];
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      op           <= OP_RD;
      owner        <= GNT_WORD;
      lane         <= '0;
      mem_wen      <= 1'b0;
      mem_ren      <= 1'b0;
      mem_waddr    <= '0;
      mem_raddr    <= '0;
      mem_wdata    <= '0;
      word_wdone   <= 1'b0;
      word_rvalid  <= 1'b0;
      word_rdata   <= '0;
      fetch_rvalid <= 1'b0;
      fetch_byte   <= '0;
      proto_err    <= 1'b0;
    end else begin
      mem_wen      <= 1'b0;
      mem_ren      <= 1'b0;
      word_wdone   <= 1'b0;
      word_rvalid  <= 1'b0;
      fetch_rvalid <= 1'b0;
      if (word_rd && word_wr) begin
        proto_err <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (word_ack) begin
            owner <= GNT_WORD;
            state <= ISSUE;
            // A simultaneous read is dropped in favour of the write.
            if (word_wr) begin
              op         <= OP_WR;
              mem_wen    <= 1'b1;
              mem_waddr  <= word_addr;
              mem_wdata  <= word_wdata;
              word_wdone <= 1'b1;
            end else begin
              op        <= OP_RD;
              mem_ren   <= 1'b1;
              mem_raddr <= word_addr;
            end
          end else if (fetch_ack) begin
            owner     <= GNT_FETCH;
            op        <= OP_RD;
            state     <= ISSUE;
            mem_ren   <= 1'b1;
            mem_raddr <= fetch_addr[ADDR_W+1:2];
            lane      <= fetch_addr[1:0];
          end
        end
        ISSUE: begin
          state <= (op == OP_WR) ? IDLE : CAPTURE;
        end
        CAPTURE: begin
          state <= IDLE;
          if (owner == GNT_WORD) begin
            word_rdata  <= mem_rdata;
            word_rvalid <= 1'b1;
          end else begin
            fetch_byte   <= lane_byte;
            fetch_rvalid <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
